// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshake and a 2-entry (main + skid) output buffer.
// Build option: define DECODE_M_EXT_EN to decode the M extension (MUL..REMU); otherwise those words are illegal.
module decode_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd_addr,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [24:0]     out_ctrl
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [24:0]     ctrl;
    } pkt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    // src1: 00 rs1, 01 pc, 10 zero; src2: 00 rs2, 01 imm; reg_src: 00 alu, 01 mem, 10 pc+4
    localparam logic [1:0] SRC1_RS1  = 2'b00;
    localparam logic [1:0] SRC1_PC   = 2'b01;
    localparam logic [1:0] SRC1_ZERO = 2'b10;
    localparam logic [1:0] SRC2_RS2  = 2'b00;
    localparam logic [1:0] SRC2_IMM  = 2'b01;
    localparam logic [1:0] RSRC_ALU  = 2'b00;
    localparam logic [1:0] RSRC_MEM  = 2'b01;
    localparam logic [1:0] RSRC_PC4  = 2'b10;

    function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [4:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        alu_op;
    logic [1:0]        src1_sel, src2_sel, mem_size, reg_src_sel;
    logic              mem_read, mem_write, mem_unsigned, reg_write;
    logic              branch, jump, ecall, ebreak, illegal, is_jalr;
    logic [2:0]        branch_cond;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]   imm_x, jalr_sum;
    pkt_t              dec_pkt;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign funct7   = in_inst[31:25];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    always_comb begin
        alu_op       = ALU_ADD;
        src1_sel     = SRC1_RS1;
        src2_sel     = SRC2_RS2;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_size     = 2'b00;
        mem_unsigned = 1'b0;
        reg_write    = 1'b0;
        reg_src_sel  = RSRC_ALU;
        branch       = 1'b0;
        branch_cond  = 3'b000;
        jump         = 1'b0;
        ecall        = 1'b0;
        ebreak       = 1'b0;
        illegal      = 1'b0;
        is_jalr      = 1'b0;
        imm32        = '0;

        case (opcode)
            OPC_LUI: begin
                imm32     = {in_inst[31:12], 12'b0};
                src1_sel  = SRC1_ZERO;
                src2_sel  = SRC2_IMM;
                reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                imm32     = {in_inst[31:12], 12'b0};
                src1_sel  = SRC1_PC;
                src2_sel  = SRC2_IMM;
                reg_write = 1'b1;
            end
            OPC_JAL: begin
                imm32       = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                               in_inst[30:21], 1'b0};
                src1_sel    = SRC1_PC;
                src2_sel    = SRC2_IMM;
                reg_write   = 1'b1;
                reg_src_sel = RSRC_PC4;
                jump        = 1'b1;
            end
            OPC_JALR: begin
                imm32       = {{20{in_inst[31]}}, in_inst[31:20]};
                src2_sel    = SRC2_IMM;
                reg_write   = 1'b1;
                reg_src_sel = RSRC_PC4;
                jump        = 1'b1;
                is_jalr     = 1'b1;
                illegal     = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm32       = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                               in_inst[11:8], 1'b0};
                alu_op      = ALU_SUB;
                branch      = 1'b1;
                branch_cond = funct3;
                illegal     = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                imm32        = {{20{in_inst[31]}}, in_inst[31:20]};
                src2_sel     = SRC2_IMM;
                mem_read     = 1'b1;
                mem_size     = funct3[1:0];
                mem_unsigned = funct3[2];
                reg_write    = 1'b1;
                reg_src_sel  = RSRC_MEM;
                illegal      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                imm32     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                src2_sel  = SRC2_IMM;
                mem_write = 1'b1;
                mem_size  = funct3[1:0];
                illegal   = (funct3 > 3'b010);
            end
            OPC_OPIMM: begin
                imm32     = {{20{in_inst[31]}}, in_inst[31:20]};
                src2_sel  = SRC2_IMM;
                reg_write = 1'b1;
                alu_op    = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
                if (funct3 == 3'b001)
                    illegal = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OPC_OP: begin
                reg_write = 1'b1;
                if (funct7 == 7'b0000000)
                    alu_op = alu_from_f3(funct3, 1'b0);
                else if ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
                    alu_op = alu_from_f3(funct3, 1'b1);
`ifdef DECODE_M_EXT_EN
                else if (funct7 == 7'b0000001)
                    alu_op = {2'b11, funct3};
`endif
                else
                    illegal = 1'b1;
            end
            OPC_SYSTEM: begin
                imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                if (in_inst == 32'h0000_0073)
                    ecall = 1'b1;
                else if (in_inst == 32'h0010_0073)
                    ebreak = 1'b1;
                else
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            branch    = 1'b0;
            jump      = 1'b0;
        end
    end

    assign imm_x    = XLEN'(imm32);
    assign jalr_sum = rs1_data + imm_x;

    always_comb begin
        dec_pkt.pc      = in_pc;
        dec_pkt.rd      = in_inst[11:7];
        dec_pkt.rs1_val = rs1_data;
        dec_pkt.rs2_val = rs2_data;
        dec_pkt.imm     = imm_x;
        dec_pkt.target  = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (in_pc + imm_x);
        dec_pkt.ctrl    = {alu_op, src1_sel, src2_sel, mem_read, mem_write, mem_size, mem_unsigned,
                           reg_write, reg_src_sel, branch, branch_cond, jump, ecall, ebreak, illegal};
    end

    pkt_t main_q, main_d, skid_q, skid_d;
    logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic accept, main_free;

    assign in_ready  = !skid_valid_q && !rst;
    assign accept    = in_valid && in_ready;
    assign main_free = !main_valid_q || out_ready;

    // Skid only fills while main is held, so main is never empty with skid occupied.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec_pkt;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_pkt;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q       <= '0;
            main_q.pc    <= RESET_PC;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_pc      = main_q.pc;
    assign out_rd_addr = main_q.rd;
    assign out_rs1_val = main_q.rs1_val;
    assign out_rs2_val = main_q.rs2_val;
    assign out_imm     = main_q.imm;
    assign out_target  = main_q.target;
    assign out_ctrl    = main_q.ctrl;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode fields, skid buffering, flush and reset.
module tb_decode_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic [4:0]      rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc, out_rs1_val, out_rs2_val, out_imm, out_target;
    logic [4:0]      out_rd_addr;
    logic [24:0]     out_ctrl;

    int checks   = 0;
    int failures = 0;

    decode_stage #(.XLEN(XLEN), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd_addr(out_rd_addr), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_imm(out_imm), .out_target(out_target), .out_ctrl(out_ctrl)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [24:0] mk_ctrl(
        input logic [4:0] alu, input logic [1:0] s1, input logic [1:0] s2,
        input logic mr, input logic mw, input logic [1:0] ms, input logic mu,
        input logic rw, input logic [1:0] rsel, input logic br, input logic [2:0] bc,
        input logic j, input logic ec, input logic eb, input logic il);
        return {alu, s1, s2, mr, mw, ms, mu, rw, rsel, br, bc, j, ec, eb, il};
    endfunction

    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0;
        rs1_data = '0; rs2_data = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_imm", out_imm, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // addi x1,x0,5
        out_ready = 1'b1; rs1_data = 32'h11; rs2_data = 32'h22;
        present(32'h0050_0093, 32'h100);
        chk("addi_rs2_addr", rs2_addr, 5);
        step();
        chk("addi_valid", out_valid, 1);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_rd", out_rd_addr, 1);
        chk("addi_imm", out_imm, 5);
        chk("addi_rs1_val", out_rs1_val, 32'h11);
        chk("addi_rs2_val", out_rs2_val, 32'h22);
        chk("addi_ctrl", out_ctrl, mk_ctrl(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        chk("addi_target", out_target, 32'h105);
        present(32'hFFF0_0093, 32'h104);
        step();
        chk("addi_neg_imm", out_imm, 32'hFFFF_FFFF);
        chk("addi_neg_target", out_target, 32'h103);
        in_valid = 1'b0;
        step();
        chk("drained_valid", out_valid, 0);

        // backpressure: three pushes with out_ready low
        out_ready = 1'b0;
        present(32'h0010_0113, 32'h200);
        step();
        chk("bp_main_valid", out_valid, 1);
        chk("bp_ready_after_1", in_ready, 1);
        present(32'h0020_0193, 32'h204);
        step();
        chk("bp_ready_after_2", in_ready, 0);
        chk("bp_main_imm", out_imm, 1);
        present(32'h0030_0213, 32'h208);
        step();
        chk("bp_ready_held", in_ready, 0);
        chk("bp_pc_held", out_pc, 32'h200);
        out_ready = 1'b1;
        step();
        chk("bp_second_pc", out_pc, 32'h204);
        chk("bp_second_rd", out_rd_addr, 3);
        chk("bp_ready_freed", in_ready, 1);
        step();
        chk("bp_third_valid", out_valid, 1);
        chk("bp_third_pc", out_pc, 32'h208);
        chk("bp_third_imm", out_imm, 3);
        in_valid = 1'b0;
        step();
        chk("bp_empty", out_valid, 0);

        // jalr x1,8(x2) then back-to-back loads
        rs1_data = 32'h1003;
        present(32'h0081_00E7, 32'h300);
        chk("jalr_rs1_addr", rs1_addr, 2);
        step();
        chk("jalr_target", out_target, 32'h100A);
        chk("jalr_ctrl", out_ctrl, mk_ctrl(0, 0, 1, 0, 0, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0));
        present(32'h0002_4183, 32'h304);
        step();
        chk("lbu_no_bubble", out_valid, 1);
        chk("lbu_pc", out_pc, 32'h304);
        chk("lbu_ctrl", out_ctrl, mk_ctrl(0, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        present(32'h0002_3183, 32'h308);
        step();
        chk("ld011_illegal", out_ctrl[0], 1);
        chk("ld011_mem_read", out_ctrl[15], 0);
        chk("ld011_reg_write", out_ctrl[10], 0);
        chk("ld011_pc", out_pc, 32'h308);

        // beq x1,x2,+16 ; bad branch funct3 ; sub ; bad OP funct7 ; ecall ; bad opcode
        present(32'h0020_8863, 32'h400);
        step();
        chk("beq_imm", out_imm, 16);
        chk("beq_target", out_target, 32'h410);
        chk("beq_ctrl", out_ctrl, mk_ctrl(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        present(32'h0020_A863, 32'h404);
        step();
        chk("br010_illegal", out_ctrl[0], 1);
        chk("br010_branch", out_ctrl[7], 0);
        present(32'h4020_80B3, 32'h408);
        step();
        chk("sub_ctrl", out_ctrl, mk_ctrl(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        present(32'h4020_90B3, 32'h40C);
        step();
        chk("sll_f7_illegal", out_ctrl[0], 1);
        present(32'h0000_0073, 32'h410);
        step();
        chk("ecall_ctrl", out_ctrl, 25'h4);
        present(32'hFFFF_FFFF, 32'h414);
        step();
        chk("badop_illegal", out_ctrl[0], 1);
        chk("badop_pc", out_pc, 32'h414);

        // M extension encoding
        present(32'h0220_8033, 32'h500);
        step();
`ifdef DECODE_M_EXT_EN
        chk("mul_alu_op", out_ctrl[24:20], 5'b11000);
        chk("mul_reg_write", out_ctrl[10], 1);
        chk("mul_illegal", out_ctrl[0], 0);
`else
        chk("mul_illegal", out_ctrl[0], 1);
        chk("mul_reg_write", out_ctrl[10], 0);
`endif
        in_valid = 1'b0;
        step();

        // flush with both entries full and a new instruction offered
        out_ready = 1'b0;
        present(32'h0010_0113, 32'h600);
        step();
        present(32'h0020_0193, 32'h604);
        step();
        present(32'h0030_0213, 32'h608);
        flush = 1'b1;
        chk("flush_ready_normal", in_ready, 0);
        step();
        chk("flush_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("flush_nothing", out_valid, 0);

        // asynchronous reset mid-transfer
        out_ready = 1'b0;
        present(32'h0010_0113, 32'h700);
        step();
        chk("midrst_loaded", out_valid, 1);
        present(32'h0020_0193, 32'h704);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_pc", out_pc, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("midrst_empty", out_valid, 0);
        chk("midrst_ready_back", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
